uart_bus_master: RTL and testbench

- Host-side bus initiator that drives the UART master port of the SOC interconnect.
- Parses a byte-oriented command stream from the UART receiver and issues single 32-bit read/write transactions on soc_if.
- Returns the response bytes to the UART transmitter.
- Lets a PC debug host peek/poke DMEM (0x1xxx_xxxx) and CSR (0x2000_0000-0x3FFF_FFFF) space while the CPU runs.

---
 rtl/uart_bus_master.sv | 169 ++++++++++++++++
 tb/tb_uart_bus_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// UART-driven debug bus master: turns 'W'/'R' byte frames from the host into single
// 32-bit soc_if accesses and streams the reply bytes back to the UART transmitter.
module uart_bus_master #(
    parameter int RX_TMO_CYC = 1_000_000,
    parameter int TMO_W      = 20
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        rx_vld,
    input  logic [7:0]  rx_data,
    output logic        tx_vld,
    input  logic        tx_rdy,
    output logic [7:0]  tx_data,
    output logic        bus_vld,
    input  logic        bus_rdy,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_wdat,
    input  logic [31:0] bus_rdat,
    output logic        err_ovr,
    output logic        err_tmo
);

    typedef enum logic [2:0] {IDLE, ADDR, WDAT, BUS, RESP} state_t;

    localparam logic [7:0]       OP_WR    = 8'h57;
    localparam logic [7:0]       OP_RD    = 8'h52;
    localparam logic [7:0]       RPL_OK   = 8'h4B;
    localparam logic [7:0]       RPL_BAD  = 8'h3F;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RX_TMO_CYC - 1);

    state_t            state, state_nxt;
    logic              is_wr;
    logic [1:0]        byte_cnt;
    logic [31:0]       addr, wdat, resp;
    logic [1:0]        resp_left;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              in_frame, tmo_hit, tx_fire, op_ok;

    assign in_frame = (state == ADDR) || (state == WDAT);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign tmo_hit  = in_frame && !rx_vld && (tmo_cnt == TMO_LAST);
    assign tx_fire  = tx_vld && tx_rdy;
    assign op_ok    = (rx_data == OP_WR) || (rx_data == OP_RD);

    assign tx_vld   = (state == RESP);
    assign tx_data  = resp[31:24];
    assign bus_vld  = (state == BUS);
    assign bus_addr = addr;
    assign bus_wdat = wdat;
    assign bus_we   = (state == BUS && is_wr) ? 4'hF : 4'h0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rx_vld) begin
                    state_nxt = op_ok ? ADDR : RESP;
                end
            end
            ADDR: begin
                if (tmo_hit) begin
                    state_nxt = IDLE;
                end else if (rx_vld && byte_cnt == 2'd3) begin
                    state_nxt = is_wr ? WDAT : BUS;
                end
            end
            WDAT: begin
                if (tmo_hit) begin
                    state_nxt = IDLE;
                end else if (rx_vld && byte_cnt == 2'd3) begin
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (bus_rdy) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (tx_fire && resp_left == 2'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame fields shift in MSB first; byte_cnt wraps to 0 after the 4th byte,
    // which is exactly the start count the data phase needs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            is_wr     <= 1'b0;
            byte_cnt  <= 2'd0;
            addr      <= 32'h0;
            wdat      <= 32'h0;
            resp      <= 32'h0;
            resp_left <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_vld) begin
                        is_wr    <= (rx_data == OP_WR);
                        byte_cnt <= 2'd0;
                        if (!op_ok) begin
                            resp      <= {RPL_BAD, 24'h0};
                            resp_left <= 2'd0;
                        end
                    end
                end
                ADDR: begin
                    if (rx_vld) begin
                        addr     <= {addr[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                WDAT: begin
                    if (rx_vld) begin
                        wdat     <= {wdat[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                BUS: begin
                    if (bus_rdy) begin
                        resp      <= is_wr ? {RPL_OK, 24'h0} : bus_rdat;
                        resp_left <= is_wr ? 2'd0 : 2'd3;
                    end
                end
                RESP: begin
                    if (tx_fire) begin
                        resp      <= {resp[23:0], 8'h0};
                        resp_left <= resp_left - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The idle counter only runs between bytes of a frame; sticky flags clear on reset only.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tmo_cnt <= '0;
            err_tmo <= 1'b0;
            err_ovr <= 1'b0;
        end else begin
            if (in_frame && !rx_vld && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            if (tmo_hit) begin
                err_tmo <= 1'b1;
            end
            if (rx_vld && (state == BUS || state == RESP)) begin
                err_ovr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: table of read/write frames plus hand-written corner cases,
// with bus and reply expectations held in scoreboard queues.
module tb_uart_bus_master;

    localparam int TMO = 16;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdat;
        logic [31:0] rdat;
        int          dly;
    } bus_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          dly;
    } vec_t;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        rx_vld = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        tx_vld;
    logic        tx_rdy = 1'b1;
    logic [7:0]  tx_data;
    logic        bus_vld;
    logic        bus_rdy = 1'b0;
    logic [31:0] bus_addr;
    logic [3:0]  bus_we;
    logic [31:0] bus_wdat;
    logic [31:0] bus_rdat = 32'h0;
    logic        err_ovr;
    logic        err_tmo;

    int   errors = 0;
    int   checks = 0;
    bus_t exp_bus[$];
    logic [7:0] exp_tx[$];
    int   vld_cycles = 0;
    logic just_done = 1'b0;
    int   stall_cnt = 0;
    int   stall_after = 0;
    int   tx_count = 0;
    int   stalled = 0;
    vec_t vecs[5];

    uart_bus_master #(.RX_TMO_CYC(TMO), .TMO_W(5)) dut (
        .clk(clk), .arst_n(arst_n),
        .rx_vld(rx_vld), .rx_data(rx_data),
        .tx_vld(tx_vld), .tx_rdy(tx_rdy), .tx_data(tx_data),
        .bus_vld(bus_vld), .bus_rdy(bus_rdy), .bus_addr(bus_addr),
        .bus_we(bus_we), .bus_wdat(bus_wdat), .bus_rdat(bus_rdat),
        .err_ovr(err_ovr), .err_tmo(err_tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus responder: raises rdy after 'dly' extra vld cycles and checks the held request.
    always @(negedge clk) begin
        if (!arst_n) begin
            bus_rdy = 1'b0;
            vld_cycles = 0;
            just_done = 1'b0;
        end else begin
            if (just_done) begin
                check("bus_vld_drop", {31'h0, bus_vld}, 32'h0);
                check("tx_vld_after_rdy", {31'h0, tx_vld}, 32'h1);
                just_done = 1'b0;
            end
            if (bus_vld) begin
                if (exp_bus.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_bus_vld: got addr %h expected no access", bus_addr);
                    bus_rdy = 1'b1;
                end else begin
                    vld_cycles++;
                    check("bus_addr", bus_addr, exp_bus[0].addr);
                    check("bus_we", {28'h0, bus_we}, {28'h0, exp_bus[0].we});
                    if (exp_bus[0].we == 4'hF) check("bus_wdat", bus_wdat, exp_bus[0].wdat);
                    bus_rdat = exp_bus[0].rdat;
                    bus_rdy = (vld_cycles == exp_bus[0].dly + 1);
                    if (bus_rdy) begin
                        void'(exp_bus.pop_front());
                        vld_cycles = 0;
                        just_done = 1'b1;
                    end
                end
            end else begin
                bus_rdy = 1'b0;
                vld_cycles = 0;
            end
        end
    end

    // Transmit sink: picks tx_rdy for the coming edge, then compares the offered byte.
    always @(negedge clk) begin
        if (stall_cnt > 0) begin
            tx_rdy = 1'b0;
            stall_cnt--;
            stalled++;
        end else begin
            tx_rdy = 1'b1;
        end
        if (arst_n && tx_vld) begin
            if (exp_tx.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_tx: got %h expected no byte", tx_data);
            end else begin
                check("tx_data", {24'h0, tx_data}, {24'h0, exp_tx[0]});
                if (tx_rdy) begin
                    void'(exp_tx.pop_front());
                    tx_count++;
                    if (tx_count == stall_after) stall_cnt = 5;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_vld = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_vld = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic wr, input logic [31:0] addr, input logic [31:0] data, input int gap);
        send_byte(wr ? 8'h57 : 8'h52, gap);
        for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8], gap);
        if (wr) for (int i = 3; i >= 0; i--) send_byte(data[i*8 +: 8], gap);
    endtask

    task automatic applyStimulus(input vec_t v, input int gap);
        bus_t t;
        t.addr = v.addr;
        t.we   = v.wr ? 4'hF : 4'h0;
        t.wdat = v.data;
        t.rdat = v.wr ? 32'h0BAD_0BAD : v.data;
        t.dly  = v.dly;
        exp_bus.push_back(t);
        if (v.wr) exp_tx.push_back(8'h4B);
        else for (int i = 3; i >= 0; i--) exp_tx.push_back(v.data[i*8 +: 8]);
        send_frame(v.wr, v.addr, v.data, gap);
    endtask

    task automatic checkOutput(input string name);
        int  n = 0;
        logic done;
        do begin
            @(posedge clk);
            #2;
            n++;
            done = (exp_tx.size() == 0) && (exp_bus.size() == 0) && !tx_vld && !bus_vld;
        end while (n < 300 && !done);
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s_complete: got pending tx=%0d bus=%0d expected drained",
                     name, exp_tx.size(), exp_bus.size());
            exp_tx.delete();
            exp_bus.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_tx_vld"}, {31'h0, tx_vld}, 32'h0);
        check({name, "_tx_data"}, {24'h0, tx_data}, 32'h0);
        check({name, "_bus_vld"}, {31'h0, bus_vld}, 32'h0);
        check({name, "_bus_addr"}, bus_addr, 32'h0);
        check({name, "_bus_we"}, {28'h0, bus_we}, 32'h0);
        check({name, "_bus_wdat"}, bus_wdat, 32'h0);
        check({name, "_err_ovr"}, {31'h0, err_ovr}, 32'h0);
        check({name, "_err_tmo"}, {31'h0, err_tmo}, 32'h0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 2};
        vecs[1] = '{1'b0, 32'h2000_0004, 32'h1234_5678, 0};
        vecs[2] = '{1'b1, 32'h3FFF_FFFC, 32'h0000_0001, 4};
        vecs[3] = '{1'b0, 32'h1000_0000, 32'hA5A5_5A5A, 3};
        vecs[4] = '{1'b0, 32'h2000_0000, 32'h8000_00FF, 1};

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        arst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], 0);
            checkOutput($sformatf("vec%0d", i));
        end

        // Reply held for 5 cycles after the first byte is taken.
        tx_count = 0;
        stalled = 0;
        stall_after = 1;
        applyStimulus('{1'b0, 32'h2000_0008, 32'hC0DE_F00D, 1}, 0);
        checkOutput("tx_stall");
        check("tx_stall_cycles", stalled, 5);
        stall_after = 0;

        exp_tx.push_back(8'h3F);
        send_byte(8'h41, 0);
        checkOutput("bad_opcode");
        applyStimulus('{1'b0, 32'h2000_0010, 32'h0F0F_0F0F, 1}, 0);
        checkOutput("after_bad");

        // 15 idle cycles between bytes: each byte lands on the expiry cycle and must win.
        applyStimulus('{1'b1, 32'h1000_0040, 32'h1357_9BDF, 1}, TMO - 1);
        checkOutput("gap_max");
        check("gap_no_tmo", {31'h0, err_tmo}, 32'h0);

        send_byte(8'h52, 0);
        send_byte(8'h20, 0);
        send_byte(8'h00, 10);
        check("tmo_early", {31'h0, err_tmo}, 32'h0);
        repeat (TMO) @(negedge clk);
        check("tmo_set", {31'h0, err_tmo}, 32'h1);
        applyStimulus('{1'b0, 32'h2000_0004, 32'h1122_3344, 2}, 0);
        checkOutput("after_tmo");

        applyStimulus('{1'b1, 32'h1000_0020, 32'hCAFE_F00D, 6}, 0);
        for (int i = 0; i < 20 && !bus_vld; i++) @(negedge clk);
        check("ovr_in_bus", {31'h0, bus_vld}, 32'h1);
        send_byte(8'h55, 0);
        check("err_ovr", {31'h0, err_ovr}, 32'h1);
        checkOutput("ovr_frame");

        send_byte(8'h57, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h80, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        arst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        arst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("post_reset");
        applyStimulus('{1'b1, 32'h1000_0100, 32'h7654_3210, 2}, 0);
        checkOutput("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
